// File: rtl/mem_boot_arbiter_if.sv
// Bus bundle for mem_boot_arbiter.
//   Loader side : I_BYTE_VALID, I_BYTE in; O_BYTE_READY out.
//   Core side   : C_ADDR, C_WDATA, C_WE, C_HALT in; C_RDATA, O_CORE_RST out.
//   Memory side : M_EN, M_WE, M_ADDR, M_WDATA out; M_RDATA in (one-cycle registered read).
// The master modport is the arbiter's view; slave is the view of whatever surrounds it.
interface mem_boot_arbiter_if #(
  parameter int unsigned ADDR_W = 6
) ();
  logic              I_BYTE_VALID;
  logic [7:0]        I_BYTE;
  logic              O_BYTE_READY;
  logic [31:0]       C_ADDR;
  logic [31:0]       C_WDATA;
  logic [3:0]        C_WE;
  logic              C_HALT;
  logic [31:0]       C_RDATA;
  logic              O_CORE_RST;
  logic              M_EN;
  logic [3:0]        M_WE;
  logic [ADDR_W-1:0] M_ADDR;
  logic [31:0]       M_WDATA;
  logic [31:0]       M_RDATA;

  modport master (
    input  I_BYTE_VALID, I_BYTE, C_ADDR, C_WDATA, C_WE, C_HALT, M_RDATA,
    output O_BYTE_READY, C_RDATA, O_CORE_RST, M_EN, M_WE, M_ADDR, M_WDATA
  );

  modport slave (
    output I_BYTE_VALID, I_BYTE, C_ADDR, C_WDATA, C_WE, C_HALT, M_RDATA,
    input  O_BYTE_READY, C_RDATA, O_CORE_RST, M_EN, M_WE, M_ADDR, M_WDATA
  );
endinterface

// File: rtl/mem_boot_arbiter.sv
// Data-memory port owner shared between a byte-stream program loader and the core.
// After reset the core is held in reset while loader bytes are packed little-endian into
// 32-bit words and written to consecutive memory words. Once LOAD_WORDS words are written
// the core is released and its data-memory traffic passes straight through. A core halt
// freezes the memory port and re-asserts core reset until the next RST.
// Ports:
//   CLK      clock, rising edge
//   RST      synchronous active-high reset
//   bus      mem_boot_arbiter_if.master (loader, core and memory signals)
//   O_STATE  0=LOAD, 1=WRITE, 2=RUN, 3=HALT
//   O_WCNT   words written so far
module mem_boot_arbiter #(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned LOAD_WORDS = 64
) (
  input  logic              CLK,
  input  logic              RST,
  mem_boot_arbiter_if.master bus,
  output logic [1:0]        O_STATE,
  output logic [ADDR_W:0]   O_WCNT
);

  typedef enum logic [1:0] {
    StLoad  = 2'd0,
    StWrite = 2'd1,
    StRun   = 2'd2,
    StHalt  = 2'd3
  } state_e;

  localparam logic [ADDR_W:0] LoadCnt = (ADDR_W + 1)'(LOAD_WORDS);

  state_e            state_q;
  logic [1:0]        byte_cnt_q;
  logic [ADDR_W:0]   word_cnt_q;
  logic [23:0]       asm_q;       // bytes 0..2 of the word; byte 3 goes straight to M_WDATA
  logic              core_rst_q;
  logic              m_en_q;
  logic [3:0]        m_we_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [31:0]       m_wdata_q;
  logic [31:0]       c_rdata_q;   // last read data seen in RUN, held through HALT
  logic [ADDR_W:0]   word_cnt_inc;
  logic              run;

  assign word_cnt_inc = word_cnt_q + (ADDR_W + 1)'(1);
  assign run          = (state_q == StRun);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StLoad;
      byte_cnt_q <= 2'd0;
      word_cnt_q <= '0;
      asm_q      <= '0;
      core_rst_q <= 1'b1;
      m_en_q     <= 1'b0;
      m_we_q     <= 4'h0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      c_rdata_q  <= '0;
    end else begin
      case (state_q)
        StLoad: begin
          if (bus.I_BYTE_VALID) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            case (byte_cnt_q)
              2'd0: asm_q[7:0]   <= bus.I_BYTE;
              2'd1: asm_q[15:8]  <= bus.I_BYTE;
              2'd2: asm_q[23:16] <= bus.I_BYTE;
              default: begin
                state_q   <= StWrite;
                m_en_q    <= 1'b1;
                m_we_q    <= 4'hF;
                m_addr_q  <= word_cnt_q[ADDR_W-1:0];
                m_wdata_q <= {bus.I_BYTE, asm_q};
              end
            endcase
          end
        end
        StWrite: begin
          word_cnt_q <= word_cnt_inc;
          m_en_q     <= 1'b0;
          m_we_q     <= 4'h0;
          if (word_cnt_inc == LoadCnt) begin
            state_q    <= StRun;
            core_rst_q <= 1'b0;
          end else begin
            state_q <= StLoad;
          end
        end
        StRun: begin
          c_rdata_q <= bus.M_RDATA;
          if (bus.C_HALT) begin
            state_q    <= StHalt;
            core_rst_q <= 1'b1;
          end
        end
        StHalt: begin
          // Only RST leaves HALT.
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  // RUN is a combinational pass-through; every other state drives the registered port.
  assign bus.O_BYTE_READY = (state_q == StLoad);
  assign bus.O_CORE_RST   = core_rst_q;
  assign bus.M_EN         = run ? 1'b1 : m_en_q;
  assign bus.M_WE         = run ? bus.C_WE : m_we_q;
  assign bus.M_ADDR       = run ? bus.C_ADDR[ADDR_W+1:2] : m_addr_q;
  assign bus.M_WDATA      = run ? bus.C_WDATA : m_wdata_q;
  assign bus.C_RDATA      = run ? bus.M_RDATA : c_rdata_q;

  assign O_STATE = state_q;
  assign O_WCNT  = word_cnt_q;

  // Byte-lane and out-of-range address bits are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.C_ADDR[31:ADDR_W+2], bus.C_ADDR[1:0]};

endmodule

// File: tb/tb_mem_boot_arbiter.sv
// Directed bench for mem_boot_arbiter: one instance with LOAD_WORDS=1, one with
// LOAD_WORDS=2 backed by a write-first registered-read memory model.
module tb_mem_boot_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] st1, st2;
  logic [6:0] wc1, wc2;
  int         total = 0;
  int         bad   = 0;

  logic [7:0]  bseq   [10];
  logic [1:0]  st_seq [10];
  logic [31:0] mem2   [64];
  logic [31:0] merged2;

  always #5 CLK = ~CLK;

  mem_boot_arbiter_if #(.ADDR_W(6)) bus1 ();
  mem_boot_arbiter_if #(.ADDR_W(6)) bus2 ();

  mem_boot_arbiter #(.ADDR_W(6), .LOAD_WORDS(1)) dut1 (
    .CLK(CLK), .RST(RST), .bus(bus1), .O_STATE(st1), .O_WCNT(wc1)
  );
  mem_boot_arbiter #(.ADDR_W(6), .LOAD_WORDS(2)) dut2 (
    .CLK(CLK), .RST(RST), .bus(bus2), .O_STATE(st2), .O_WCNT(wc2)
  );

  always_comb begin
    merged2 = mem2[bus2.M_ADDR];
    if (bus2.M_WE[0]) merged2[7:0]   = bus2.M_WDATA[7:0];
    if (bus2.M_WE[1]) merged2[15:8]  = bus2.M_WDATA[15:8];
    if (bus2.M_WE[2]) merged2[23:16] = bus2.M_WDATA[23:16];
    if (bus2.M_WE[3]) merged2[31:24] = bus2.M_WDATA[31:24];
  end

  always @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 64; i++) mem2[i] <= '0;
      bus2.M_RDATA <= '0;
    end else if (bus2.M_EN) begin
      mem2[bus2.M_ADDR] <= merged2;
      bus2.M_RDATA      <= merged2;
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bseq   = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h15, 8'h16, 8'h17, 8'h18, 8'h18};
    st_seq = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
    RST = 1'b1;
    bus1.I_BYTE_VALID = 1'b0; bus1.I_BYTE = '0; bus1.C_ADDR = '0; bus1.C_WDATA = '0;
    bus1.C_WE = '0; bus1.C_HALT = 1'b0; bus1.M_RDATA = '0;
    bus2.I_BYTE_VALID = 1'b0; bus2.I_BYTE = '0; bus2.C_ADDR = '0; bus2.C_WDATA = '0;
    bus2.C_WE = '0; bus2.C_HALT = 1'b0;
    cyc();
    cyc();

    // Reset state
    chk("rst_state", st2, 2'd0);
    chk("rst_wcnt", wc2, 7'd0);
    chk("rst_core_rst", bus2.O_CORE_RST, 1'b1);
    chk("rst_ready", bus2.O_BYTE_READY, 1'b1);
    chk("rst_m_en", bus2.M_EN, 1'b0);
    chk("rst_m_we", bus2.M_WE, 4'h0);
    chk("rst_m_addr", bus2.M_ADDR, 6'd0);
    chk("rst_m_wdata", bus2.M_WDATA, 32'h0);
    chk("rst_c_rdata", bus2.C_RDATA, 32'h0);
    RST = 1'b0;

    // Single-word load on the LOAD_WORDS=1 instance
    bus1.I_BYTE_VALID = 1'b1;
    bus1.I_BYTE = 8'h93; cyc();
    bus1.I_BYTE = 8'h01; cyc();
    bus1.I_BYTE = 8'hD0; cyc();
    bus1.I_BYTE = 8'h00; cyc();
    bus1.I_BYTE_VALID = 1'b0;
    #1;
    chk("sw_state_write", st1, 2'd1);
    chk("sw_m_en", bus1.M_EN, 1'b1);
    chk("sw_m_we", bus1.M_WE, 4'hF);
    chk("sw_m_addr", bus1.M_ADDR, 6'd0);
    chk("sw_m_wdata", bus1.M_WDATA, 32'h00D00193);
    chk("sw_ready_write", bus1.O_BYTE_READY, 1'b0);
    cyc();
    chk("sw_state_run", st1, 2'd2);
    chk("sw_core_rst", bus1.O_CORE_RST, 1'b0);
    chk("sw_wcnt", wc1, 7'd1);

    // Backpressure: valid held high, WRITE cycles stall the stream
    bus2.I_BYTE_VALID = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus2.I_BYTE = bseq[i];
      #1;
      chk("bp_state", st2, st_seq[i]);
      chk("bp_ready", bus2.O_BYTE_READY, (st_seq[i] == 2'd0));
      if (i == 4) begin
        chk("bp_w0_data", bus2.M_WDATA, 32'h14131211);
        chk("bp_w0_addr", bus2.M_ADDR, 6'd0);
      end
      if (i == 9) begin
        chk("bp_w1_data", bus2.M_WDATA, 32'h18171615);
        chk("bp_w1_addr", bus2.M_ADDR, 6'd1);
      end
      cyc();
    end
    bus2.I_BYTE_VALID = 1'b0;
    #1;
    chk("bp_state_run", st2, 2'd2);
    chk("bp_core_rst", bus2.O_CORE_RST, 1'b0);
    chk("bp_wcnt", wc2, 7'd2);
    chk("bp_ready_run", bus2.O_BYTE_READY, 1'b0);
    chk("bp_mem0", mem2[0], 32'h14131211);
    chk("bp_mem1", mem2[1], 32'h18171615);

    // Pass-through in RUN
    bus2.C_ADDR = 32'h0000000C; bus2.C_WE = 4'b0011; bus2.C_WDATA = 32'hCAFEBABE;
    #1;
    chk("pt_m_en", bus2.M_EN, 1'b1);
    chk("pt_m_addr", bus2.M_ADDR, 6'd3);
    chk("pt_m_we", bus2.M_WE, 4'b0011);
    chk("pt_m_wdata", bus2.M_WDATA, 32'hCAFEBABE);
    cyc();
    bus2.C_WE = 4'h0; bus2.C_ADDR = 32'hFFFFFF0F;
    #1;
    chk("pt_c_rdata", bus2.C_RDATA, 32'h0000BABE);
    chk("pt_addr_mask", bus2.M_ADDR, 6'd3);

    // Halt; the write in the transition cycle still reaches memory
    bus2.C_HALT = 1'b1; bus2.C_WE = 4'b1100; bus2.C_WDATA = 32'h12345678;
    bus2.C_ADDR = 32'h00000014;
    #1;
    chk("ht_last_we", bus2.M_WE, 4'b1100);
    cyc();
    bus2.C_HALT = 1'b0; bus2.C_WE = 4'hF; bus2.C_WDATA = 32'hDEADBEEF;
    bus2.C_ADDR = 32'h00000010; bus2.I_BYTE_VALID = 1'b1; bus2.I_BYTE = 8'h55;
    #1;
    chk("ht_state", st2, 2'd3);
    chk("ht_core_rst", bus2.O_CORE_RST, 1'b1);
    chk("ht_m_en", bus2.M_EN, 1'b0);
    chk("ht_m_we", bus2.M_WE, 4'h0);
    chk("ht_ready", bus2.O_BYTE_READY, 1'b0);
    chk("ht_c_rdata", bus2.C_RDATA, 32'h0000BABE);
    cyc();
    cyc();
    chk("ht_mem4", mem2[4], 32'h0);
    chk("ht_mem5", mem2[5], 32'h12340000);
    chk("ht_state_hold", st2, 2'd3);
    chk("ht_wcnt", wc2, 7'd2);

    // Reset mid-load
    bus2.I_BYTE_VALID = 1'b0; bus2.C_WE = 4'h0; bus2.C_WDATA = '0; bus2.C_ADDR = '0;
    RST = 1'b1;
    cyc();
    chk("rh_state", st2, 2'd0);
    RST = 1'b0;
    bus2.I_BYTE_VALID = 1'b1;
    bus2.I_BYTE = 8'hA0; cyc();
    bus2.I_BYTE = 8'hA1; cyc();
    bus2.I_BYTE = 8'hA2; cyc();
    bus2.I_BYTE = 8'hA3; cyc();
    bus2.I_BYTE_VALID = 1'b0;
    cyc();
    chk("rm_w0_wcnt", wc2, 7'd1);
    bus2.I_BYTE_VALID = 1'b1;
    bus2.I_BYTE = 8'hBB; cyc();
    bus2.I_BYTE = 8'hBC; cyc();
    bus2.I_BYTE_VALID = 1'b0;
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    #1;
    chk("rm_wcnt", wc2, 7'd0);
    chk("rm_state", st2, 2'd0);
    chk("rm_core_rst", bus2.O_CORE_RST, 1'b1);
    chk("rm_ready", bus2.O_BYTE_READY, 1'b1);
    bus2.I_BYTE_VALID = 1'b1;
    bus2.I_BYTE = 8'hC0; cyc();
    bus2.I_BYTE = 8'hC1; cyc();
    bus2.I_BYTE = 8'hC2; cyc();
    bus2.I_BYTE = 8'hC3; cyc();
    bus2.I_BYTE_VALID = 1'b0;
    #1;
    chk("rm_reload_state", st2, 2'd1);
    chk("rm_reload_addr", bus2.M_ADDR, 6'd0);
    chk("rm_reload_data", bus2.M_WDATA, 32'hC3C2C1C0);
    cyc();
    chk("rm_reload_wcnt", wc2, 7'd1);
    chk("rm_reload_back", st2, 2'd0);

    // C_HALT held through LOAD is ignored until RUN
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    bus1.C_HALT = 1'b1;
    bus1.I_BYTE_VALID = 1'b1;
    bus1.I_BYTE = 8'h01; cyc();
    chk("ih_state_load", st1, 2'd0);
    bus1.I_BYTE = 8'h02; cyc();
    bus1.I_BYTE = 8'h03; cyc();
    bus1.I_BYTE = 8'h04; cyc();
    bus1.I_BYTE_VALID = 1'b0;
    #1;
    chk("ih_state_write", st1, 2'd1);
    chk("ih_wdata", bus1.M_WDATA, 32'h04030201);
    cyc();
    chk("ih_state_run", st1, 2'd2);
    chk("ih_core_rst_run", bus1.O_CORE_RST, 1'b0);
    cyc();
    chk("ih_state_halt", st1, 2'd3);
    chk("ih_core_rst_halt", bus1.O_CORE_RST, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_boot_arbiter.md
Name: mem_boot_arbiter

Overview:
- Owns the data-memory port shared between a byte-stream program loader and the UltraSmall core.
- After reset it holds the core in reset and packs incoming bytes into 32-bit little-endian words.
- It writes those words into consecutive memory words, then releases the core and passes the core's data-memory traffic straight through.
- On core halt it freezes the memory port and re-asserts core reset until the next RST.

Parameters:
- ADDR_W, 6, memory word-address width (MEM_SIZE/4 entries).
- LOAD_WORDS, 64, number of words loaded before the core is released; range 1..2^ADDR_W.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- I_BYTE_VALID  in  1  loader byte valid.
- I_BYTE  in  8  loader byte.
- O_BYTE_READY  out  1  block accepts I_BYTE this cycle.
- C_ADDR  in  32  core data byte address.
- C_WDATA  in  32  core write data.
- C_WE  in  4  core byte write enables.
- C_HALT  in  1  core halt flag.
- C_RDATA  out  32  read data returned to the core.
- O_CORE_RST  out  1  core reset, active-high; the top level inverts it for the core's active-low input.
- M_EN  out  1  memory port enable.
- M_WE  out  4  memory byte write enables.
- M_ADDR  out  ADDR_W  memory word address.
- M_WDATA  out  32  memory write data.
- M_RDATA  in  32  memory read data; one-cycle registered read.
- O_STATE  out  2  encoding: LOAD=0, WRITE=1, RUN=2, HALT=3.
- O_WCNT  out  ADDR_W+1  words written so far.

Behaviour:
- Reset (RST=1 at a clock edge, any state, including mid-load or mid-run):
  - state=LOAD; byte_cnt=0; word_cnt=0; assembly register=0.
  - O_CORE_RST=1, O_BYTE_READY=1 (from the next cycle).
  - M_EN=0, M_WE=0, M_ADDR=0, M_WDATA=0; C_RDATA=0.
- LOAD:
  - O_BYTE_READY=1; a byte is accepted on a cycle where I_BYTE_VALID & O_BYTE_READY.
  - Accepted byte k (k=byte_cnt) goes into assembly bits [8k+7:8k], i.e. the first byte lands in [7:0] (little-endian); byte_cnt increments mod 4.
  - When the 4th byte is accepted, go to WRITE on the next edge, registering M_EN=1, M_WE=4'hF, M_ADDR=word_cnt[ADDR_W-1:0], M_WDATA={I_BYTE, asm[23:0]}.
  - Memory port is otherwise idle in LOAD: M_EN=0, M_WE=0.
- WRITE (exactly one cycle):
  - Memory write is presented; O_BYTE_READY=0, so a held I_BYTE_VALID is not consumed and stays pending.
  - word_cnt increments at the end of the cycle.
  - If the new word_cnt == LOAD_WORDS, go to RUN; else return to LOAD.
  - Registered M_EN/M_WE return to 0 on leaving WRITE.
- RUN:
  - O_CORE_RST=0, registered: it first reads 0 in the first RUN cycle.
  - Combinational pass-through: M_EN=1, M_WE=C_WE, M_ADDR=C_ADDR[ADDR_W+1:2], M_WDATA=C_WDATA, C_RDATA=M_RDATA.
  - O_BYTE_READY=0; loader bytes are ignored.
  - C_HALT=1 at an edge moves the state to HALT.
- HALT:
  - M_EN=0, M_WE=0; C_RDATA holds its last value.
  - O_CORE_RST=1 from the first HALT cycle; O_BYTE_READY=0.
  - Only RST leaves HALT.
- Boundary conditions:
  - C_HALT in LOAD/WRITE is ignored (the core is in reset).
  - Core writes present in the cycle of the RUN→HALT transition are still passed to memory.
  - C_ADDR bits [1:0] and bits above ADDR_W+1 are ignored.
  - A partial word (byte_cnt≠0) is never written.
  - LOAD_WORDS=2^ADDR_W loads the full memory; O_WCNT reaches 2^ADDR_W without wrapping.
- Latency: 4th byte accepted in cycle t → write on the port in cycle t+1 → O_STATE reflects LOAD or RUN in cycle t+2.

Test Plan:
- Single-word load: LOAD_WORDS=1; bytes 0x93,0x01,0xD0,0x00 on consecutive cycles.
  → One cycle with M_EN=1, M_WE=F, M_ADDR=0, M_WDATA=0x00D00193.
  → Next cycle O_STATE=RUN and O_CORE_RST=0; O_WCNT=1.
- Backpressure: LOAD_WORDS=2; I_BYTE_VALID held high with bytes 0x11..0x18.
  → O_BYTE_READY=0 during each WRITE cycle and byte 0x15 is not lost.
  → Word 0=0x14131211, word 1=0x18171615.
  → Exactly 10 cycles from the first accepted byte to the first RUN cycle.
- Pass-through: in RUN, drive C_ADDR=0x0000000C, C_WE=4'b0011, C_WDATA=0xCAFEBABE.
  → Same cycle M_ADDR=3, M_WE=0011, M_WDATA=0xCAFEBABE.
  → Memory returns 0x0000BABE → C_RDATA=0x0000BABE one cycle later.
- Halt: assert C_HALT in RUN.
  → Next cycle O_STATE=HALT, O_CORE_RST=1, M_EN=0.
  → Subsequent C_WE=F and I_BYTE_VALID have no effect.
- Reset mid-load: RST after 2 of 4 bytes of word 1.
  → Next cycle O_WCNT=0, O_STATE=LOAD, O_CORE_RST=1.
  → Reload of 4 bytes writes to M_ADDR=0 with no residue of the old partial bytes.
- Ignore halt during load: C_HALT=1 throughout LOAD → load completes, RUN is entered, then HALT on the next edge.
